// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | muldiv_sequencer_if : EX-stage issue / HI-LO result bundle for the          |
// |                       multiply/divide sequencer                             |
// | Optional cancel signal present when MULDIV_SEQUENCER_CANCEL_EN is defined.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             md_use;
`ifdef MULDIV_SEQUENCER_CANCEL_EN
    logic             cancel;
`endif
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic [7:0]       count_down;
    logic             stall;
    logic             done;
    logic             conflict;

`ifdef MULDIV_SEQUENCER_CANCEL_EN
    modport master (
        output start, op, A, B, md_use, cancel,
        input  HI, LO, busy, count_down, stall, done, conflict
    );
    modport slave (
        input  start, op, A, B, md_use, cancel,
        output HI, LO, busy, count_down, stall, done, conflict
    );
`else
    modport master (
        output start, op, A, B, md_use,
        input  HI, LO, busy, count_down, stall, done, conflict
    );
    modport slave (
        input  start, op, A, B, md_use,
        output HI, LO, busy, count_down, stall, done, conflict
    );
`endif
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | muldiv_sequencer : HI/LO owner and fixed-latency multiply/divide sequencer  |
// | Macro MULDIV_SEQUENCER_CANCEL_EN adds an exception-flush cancel input.      |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module muldiv_sequencer #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic         clk,
    input  wire logic         reset,
    muldiv_sequencer_if.slave bus
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [7:0]       MULT_N   = 8'(MULT_CYCLES);
    localparam logic [7:0]       DIV_N    = 8'(DIV_CYCLES);
    localparam logic [WIDTH-1:0] SIGN_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   hi_q, lo_q, s_hi_q, s_lo_q;
    logic [WIDTH-1:0]   s_hi_d, s_lo_d;
    logic [7:0]         count_q;
    logic               done_q, conflict_q;
    logic               cancel_act;

    logic signed [2*WIDTH-1:0] a_sx, b_sx, prod_s;
    logic        [2*WIDTH-1:0] prod_u;

`ifdef MULDIV_SEQUENCER_CANCEL_EN
    assign cancel_act = bus.cancel;
`else
    assign cancel_act = 1'b0;
`endif

    // Shadow result; divide-by-zero keeps the current HI/LO so commit is a no-op
    always_comb begin
        a_sx   = {{WIDTH{bus.A[WIDTH-1]}}, bus.A};
        b_sx   = {{WIDTH{bus.B[WIDTH-1]}}, bus.B};
        prod_s = a_sx * b_sx;
        prod_u = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
        s_hi_d = hi_q;
        s_lo_d = lo_q;
        case (bus.op)
            OP_MULT:  {s_hi_d, s_lo_d} = prod_s;
            OP_MULTU: {s_hi_d, s_lo_d} = prod_u;
            OP_DIV: begin
                if (bus.B != '0) begin
                    if (bus.A == SIGN_MIN && bus.B == '1) begin
                        s_lo_d = SIGN_MIN;
                        s_hi_d = '0;
                    end else begin
                        s_lo_d = $signed(bus.A) / $signed(bus.B);
                        s_hi_d = $signed(bus.A) % $signed(bus.B);
                    end
                end
            end
            OP_DIVU: begin
                if (bus.B != '0) begin
                    s_lo_d = bus.A / bus.B;
                    s_hi_d = bus.A % bus.B;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            s_hi_q     <= '0;
            s_lo_q     <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !cancel_act) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                s_hi_q  <= s_hi_d;
                                s_lo_q  <= s_lo_d;
                                count_q <= MULT_N;
                                state_q <= S_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                s_hi_q  <= s_hi_d;
                                s_lo_q  <= s_lo_d;
                                count_q <= DIV_N;
                                state_q <= S_RUN;
                            end
                            OP_MTHI: hi_q <= bus.A;
                            OP_MTLO: lo_q <= bus.A;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (bus.start) begin
                        conflict_q <= 1'b1;
                    end
                    // Flush wins over a commit that would land on this same edge
                    if (cancel_act) begin
                        count_q <= '0;
                        state_q <= S_IDLE;
                    end else if (count_q == 8'd1) begin
                        hi_q    <= s_hi_q;
                        lo_q    <= s_lo_q;
                        count_q <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        count_q <= count_q - 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.HI         = hi_q;
    assign bus.LO         = lo_q;
    assign bus.busy       = (state_q == S_RUN);
    assign bus.count_down = count_q;
    assign bus.done       = done_q;
    assign bus.conflict   = conflict_q;
    assign bus.stall      = bus.md_use & ((state_q == S_RUN) | bus.start);
endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_muldiv_sequencer : directed + random bench with an arithmetic HI/LO model|
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_muldiv_sequencer;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    logic [31:0] m_hi, m_lo;
    logic        m_conflict;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(
        .WIDTH       (32),
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics computed with 64-bit integer arithmetic
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, b,
                                          input logic [31:0] hi, lo);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     res;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = {hi, lo};
        case (o)
            3'd0: res = sa * sb;
            3'd1: res = ua * ub;
            3'd2: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            3'd3: if (b != 0) begin
                q = longint'(ua / ub);
                r = longint'(ua % ub);
                res = {r[31:0], q[31:0]};
            end
            default: ;
        endcase
        return res;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle; inj >= 0 drops an extra MTLO at that busy cycle
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, b, input logic md, input int inj);
        logic [63:0] exp;
        int          n;
        bus.start  = 1'b1;
        bus.op     = o;
        bus.A      = a;
        bus.B      = b;
        bus.md_use = md;
        #1;
        chk("stall_issue", bus.stall, md);
        exp = model(o, a, b, m_hi, m_lo);
        step();
        bus.start = 1'b0;
        chk("done_after_issue", bus.done, 0);
        if (o >= 3'd4) begin
            if (o == 3'd4) m_hi = a;
            if (o == 3'd5) m_lo = a;
            chk("imm_busy", bus.busy, 0);
            chk("imm_count", bus.count_down, 0);
            chk("imm_hi", bus.HI, m_hi);
            chk("imm_lo", bus.LO, m_lo);
        end else begin
            n = (o < 3'd2) ? MC : DC;
            for (int i = 0; i < n; i++) begin
                chk("run_busy", bus.busy, 1);
                chk("run_count", bus.count_down, 64'(n - i));
                chk("run_hi_hold", bus.HI, m_hi);
                chk("run_lo_hold", bus.LO, m_lo);
                chk("run_stall", bus.stall, md);
                chk("run_done", bus.done, 0);
                if (i == inj) begin
                    bus.start  = 1'b1;
                    bus.op     = 3'd5;
                    bus.A      = $urandom;
                    m_conflict = 1'b1;
                end
                step();
                bus.start = 1'b0;
            end
            {m_hi, m_lo} = exp;
            chk("cmt_busy", bus.busy, 0);
            chk("cmt_count", bus.count_down, 0);
            chk("cmt_done", bus.done, 1);
            chk("cmt_hi", bus.HI, m_hi);
            chk("cmt_lo", bus.LO, m_lo);
            chk("cmt_stall", bus.stall, 0);
        end
        chk("conflict", bus.conflict, m_conflict);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        vectors     = 0;
        miscompares = 0;
        m_hi        = '0;
        m_lo        = '0;
        m_conflict  = 1'b0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = '0;
        bus.A       = '0;
        bus.B       = '0;
        bus.md_use  = 1'b1;
`ifdef MULDIV_SEQUENCER_CANCEL_EN
        bus.cancel  = 1'b0;
`endif
        step();
        step();
        chk("rst_hi", bus.HI, 0);
        chk("rst_lo", bus.LO, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_count", bus.count_down, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_conflict", bus.conflict, 0);
        chk("rst_stall", bus.stall, 0);
        reset = 1'b0;
        step();

        do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, -1);
        chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
        chk("mult_lo", bus.LO, 32'hFFFF_FFFA);
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, -1);
        chk("multu_hi", bus.HI, 32'h0000_0001);
        chk("multu_lo", bus.LO, 32'hFFFF_FFFE);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
        chk("div_hi", bus.HI, 32'hFFFF_FFFF);
        chk("div_lo", bus.LO, 32'hFFFF_FFFD);
        do_op(3'd4, 32'h11, 32'd0, 1'b0, -1);
        do_op(3'd5, 32'h22, 32'd0, 1'b0, -1);
        do_op(3'd3, 32'd7, 32'd0, 1'b0, -1);
        chk("divu0_hi", bus.HI, 32'h11);
        chk("divu0_lo", bus.LO, 32'h22);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
        chk("divovf_hi", bus.HI, 32'h0);
        chk("divovf_lo", bus.LO, 32'h8000_0000);
        do_op(3'd4, 32'h1234, 32'd0, 1'b0, -1);
        chk("mthi_hi", bus.HI, 32'h1234);
        do_op(3'd0, $urandom, $urandom, 1'b0, 1);
        chk("conflict_set", bus.conflict, 1);
        do_op(3'd2, $urandom, $urandom_range(1, 1000), 1'b1, -1);
        do_op(3'd3, $urandom, $urandom_range(1, 1000), 1'b0, -1);
        do_op(3'd6, $urandom, $urandom, 1'b1, -1);
        do_op(3'd7, $urandom, $urandom, 1'b0, -1);

        // Asynchronous reset in the middle of a MULT
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.A     = 32'd100;
        bus.B     = 32'd100;
        step();
        bus.start = 1'b0;
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        m_hi       = '0;
        m_lo       = '0;
        m_conflict = 1'b0;
        chk("arst_hi", bus.HI, 0);
        chk("arst_lo", bus.LO, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_count", bus.count_down, 0);
        chk("arst_conflict", bus.conflict, 0);
        step();
        reset = 1'b0;
        step();
        do_op(3'd0, 32'd2, 32'd3, 1'b0, -1);
        chk("post_rst_lo", bus.LO, 32'd6);
        chk("post_rst_hi", bus.HI, 32'd0);

`ifdef MULDIV_SEQUENCER_CANCEL_EN
        // Cancel on the final busy cycle must beat the commit
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.A     = 32'd7;
        bus.B     = 32'd9;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < MC; i++) begin
            chk("cnl_count", bus.count_down, 64'(MC - i));
            if (i == MC - 1) bus.cancel = 1'b1;
            step();
        end
        bus.cancel = 1'b0;
        chk("cnl_busy", bus.busy, 0);
        chk("cnl_count0", bus.count_down, 0);
        chk("cnl_hi", bus.HI, m_hi);
        chk("cnl_lo", bus.LO, m_lo);
        step();
        chk("cnl_done", bus.done, 0);
        bus.start  = 1'b1;
        bus.op     = 3'd4;
        bus.A      = 32'hDEAD_BEEF;
        bus.cancel = 1'b1;
        step();
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        chk("cnl_mthi", bus.HI, m_hi);
        chk("cnl_idle_busy", bus.busy, 0);
`endif

        for (int k = 0; k < 40; k++) begin
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 16));
                default: rb = $urandom;
            endcase
            do_op(ro, ra, rb, 1'($urandom_range(0, 1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
